// File: rtl/register_file_pkg.sv
// Shared CPU constants and types used by the destination-select, ALU and
// register-file stages.
package register_file_pkg;

    localparam int CPU_DATA_WIDTH = 16;
    localparam int CPU_REG_COUNT  = 4;
    localparam int CPU_REG_ADDR_W = 2;

    typedef logic [CPU_REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CPU_DATA_WIDTH-1:0] cpu_data_t;

    // Destination-select stage choices for the write-back index.
    typedef enum logic [1:0] {
        DST_RT   = 2'd0,
        DST_RD   = 2'd1,
        DST_LINK = 2'd2
    } dest_sel_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

endpackage

// File: rtl/register_file.sv
// Register array with a one-entry write-back latch: writes commit one edge
// after capture, and the latched value is bypassed to both read ports.
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int REG_COUNT  = CPU_REG_COUNT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      Clear,
    input  logic                      Stall,
    input  logic                      RegWrite,
    input  logic [CPU_REG_ADDR_W-1:0] Write_Register,
    input  logic [DATA_WIDTH-1:0]     Write_Data,
    input  logic [CPU_REG_ADDR_W-1:0] Read_Register1,
    input  logic [CPU_REG_ADDR_W-1:0] Read_Register2,
    output logic [DATA_WIDTH-1:0]     Read_Data1,
    output logic [DATA_WIDTH-1:0]     Read_Data2,
    output logic                      Committed
);

    logic [REG_COUNT*DATA_WIDTH-1:0] regs;
    logic                            wb_valid;
    logic [CPU_REG_ADDR_W-1:0]       wb_addr;
    logic [DATA_WIDTH-1:0]           wb_data;

    // Clear beats Stall, and the pending commit is dropped with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs      <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            Committed <= 1'b0;
        end else if (Clear) begin
            regs      <= '0;
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            Committed <= 1'b0;
        end else if (Stall) begin
            Committed <= 1'b0;
        end else begin
            wb_valid  <= RegWrite;
            wb_addr   <= Write_Register;
            wb_data   <= Write_Data;
            Committed <= wb_valid;
            if (wb_valid) begin
                for (int unsigned i = 0; i < REG_COUNT; i++) begin
                    if (wb_addr == CPU_REG_ADDR_W'(i)) begin
                        regs[i*DATA_WIDTH +: DATA_WIDTH] <= wb_data;
                    end
                end
            end
        end
    end

    always_comb begin
        Read_Data1 = '0;
        Read_Data2 = '0;
        for (int unsigned i = 0; i < REG_COUNT; i++) begin
            if (Read_Register1 == CPU_REG_ADDR_W'(i)) begin
                Read_Data1 = regs[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (Read_Register2 == CPU_REG_ADDR_W'(i)) begin
                Read_Data2 = regs[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (wb_valid && (wb_addr == Read_Register1)) begin
            Read_Data1 = wb_data;
        end
        if (wb_valid && (wb_addr == Read_Register2)) begin
            Read_Data2 = wb_data;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Directed vectors for register_file; each cycle's expected read/commit values
// are queued by the driver and checked by a separate monitor on the falling edge.
module tb_register_file;

    logic        clk;
    logic        reset_n;
    logic        Clear;
    logic        Stall;
    logic        RegWrite;
    logic [1:0]  Write_Register;
    logic [15:0] Write_Data;
    logic [1:0]  Read_Register1;
    logic [1:0]  Read_Register2;
    logic [15:0] Read_Data1;
    logic [15:0] Read_Data2;
    logic        Committed;

    register_file #(
        .DATA_WIDTH(16),
        .REG_COUNT (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .Clear         (Clear),
        .Stall         (Stall),
        .RegWrite      (RegWrite),
        .Write_Register(Write_Register),
        .Write_Data    (Write_Data),
        .Read_Register1(Read_Register1),
        .Read_Register2(Read_Register2),
        .Read_Data1    (Read_Data1),
        .Read_Data2    (Read_Data2),
        .Committed     (Committed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rstn;
        logic        clr;
        logic        stall;
        logic        rw;
        logic [1:0]  wr;
        logic [15:0] wd;
        logic [1:0]  r1;
        logic [1:0]  r2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        ec;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        ec;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic add(input string name, input logic rstn, input logic clr,
                       input logic stall, input logic rw, input logic [1:0] wr,
                       input logic [15:0] wd, input logic [1:0] r1, input logic [1:0] r2,
                       input logic [15:0] e1, input logic [15:0] e2, input logic ec);
        vec_t v;
        v.name = name; v.rstn = rstn; v.clr = clr; v.stall = stall;
        v.rw = rw; v.wr = wr; v.wd = wd; v.r1 = r1; v.r2 = r2;
        v.e1 = e1; v.e2 = e2; v.ec = ec;
        vecs.push_back(v);
    endtask

    // Monitor: one queued expectation per cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (Read_Data1 !== e.e1) begin
                fails++;
                $display("FAIL %s rd1: got %h expected %h", e.name, Read_Data1, e.e1);
            end
            checks++;
            if (Read_Data2 !== e.e2) begin
                fails++;
                $display("FAIL %s rd2: got %h expected %h", e.name, Read_Data2, e.e2);
            end
            checks++;
            if (Committed !== e.ec) begin
                fails++;
                $display("FAIL %s committed: got %b expected %b", e.name, Committed, e.ec);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; Clear = 1'b0; Stall = 1'b0; RegWrite = 1'b0;
        Write_Register = '0; Write_Data = '0; Read_Register1 = '0; Read_Register2 = '0;

        //   name        rstn clr stl rw wr  wd        r1 r2  e1        e2        ec
        add("rst",       0,   0,  0,  0, 0, 16'h0000, 2, 3, 16'h0000, 16'h0000, 0);
        add("w2_same",   1,   0,  0,  1, 2, 16'h1234, 2, 0, 16'h0000, 16'h0000, 0);
        add("w2_byp",    1,   0,  0,  0, 0, 16'h0000, 2, 2, 16'h1234, 16'h1234, 0);
        add("w2_arr",    1,   0,  0,  0, 0, 16'h0000, 2, 0, 16'h1234, 16'h0000, 1);
        add("w2_once",   1,   0,  0,  0, 0, 16'h0000, 2, 0, 16'h1234, 16'h0000, 0);
        add("w1_old",    1,   0,  0,  1, 1, 16'hBEEF, 1, 2, 16'h0000, 16'h1234, 0);
        add("w1_byp",    1,   0,  0,  0, 0, 16'h0000, 1, 1, 16'hBEEF, 16'hBEEF, 0);
        add("w3_cap",    1,   0,  0,  1, 3, 16'h00AA, 3, 1, 16'h0000, 16'hBEEF, 1);
        add("stall1",    1,   0,  1,  1, 0, 16'hFFFF, 3, 0, 16'h00AA, 16'h0000, 0);
        add("stall2",    1,   0,  1,  1, 0, 16'hFFFF, 3, 0, 16'h00AA, 16'h0000, 0);
        add("stall3",    1,   0,  1,  1, 0, 16'hFFFF, 3, 0, 16'h00AA, 16'h0000, 0);
        add("unstall",   1,   0,  0,  0, 0, 16'h0000, 3, 0, 16'h00AA, 16'h0000, 0);
        add("w3_commit", 1,   0,  0,  0, 0, 16'h0000, 3, 0, 16'h00AA, 16'h0000, 1);
        add("w3_once",   1,   0,  0,  0, 0, 16'h0000, 3, 0, 16'h00AA, 16'h0000, 0);
        add("r0_a",      1,   0,  0,  1, 0, 16'h0001, 3, 0, 16'h00AA, 16'h0000, 0);
        add("r0_b",      1,   0,  0,  1, 0, 16'h0002, 3, 0, 16'h00AA, 16'h0001, 0);
        add("r0_byp2",   1,   0,  0,  0, 0, 16'h0000, 0, 0, 16'h0002, 16'h0002, 1);
        add("r0_final",  1,   0,  0,  0, 0, 16'h0000, 0, 1, 16'h0002, 16'hBEEF, 1);
        add("r1_5555",   1,   0,  0,  1, 1, 16'h5555, 1, 2, 16'hBEEF, 16'h1234, 0);
        add("r1_byp5",   1,   0,  0,  0, 0, 16'h0000, 1, 0, 16'h5555, 16'h0002, 0);
        add("r1_7777",   1,   0,  0,  1, 1, 16'h7777, 1, 1, 16'h5555, 16'h5555, 1);
        add("clr",       1,   1,  0,  0, 0, 16'h0000, 1, 1, 16'h7777, 16'h7777, 0);
        add("clr_r12",   1,   0,  0,  0, 0, 16'h0000, 1, 2, 16'h0000, 16'h0000, 0);
        add("clr_r13",   1,   0,  0,  0, 0, 16'h0000, 1, 3, 16'h0000, 16'h0000, 0);
        add("clr_r00",   1,   0,  0,  0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
        add("nowr",      1,   0,  0,  0, 2, 16'hDEAD, 2, 2, 16'h0000, 16'h0000, 0);
        add("nowr_byp",  1,   0,  0,  0, 0, 16'h0000, 2, 2, 16'h0000, 16'h0000, 0);
        add("nowr_arr",  1,   0,  0,  0, 0, 16'h0000, 2, 2, 16'h0000, 16'h0000, 0);
        add("w3_cafe",   1,   0,  0,  1, 3, 16'hCAFE, 3, 0, 16'h0000, 16'h0000, 0);
        add("clr_stall", 1,   1,  1,  1, 2, 16'h1111, 3, 0, 16'hCAFE, 16'h0000, 0);
        add("clr_st_r",  1,   0,  0,  0, 0, 16'h0000, 3, 2, 16'h0000, 16'h0000, 0);
        add("w2_abcd",   1,   0,  0,  1, 2, 16'hABCD, 2, 0, 16'h0000, 16'h0000, 0);
        add("w3_4321",   1,   0,  0,  1, 3, 16'h4321, 2, 2, 16'hABCD, 16'hABCD, 0);
        add("w1_9999",   1,   0,  0,  1, 1, 16'h9999, 2, 3, 16'hABCD, 16'h4321, 1);
        add("rst_mid",   0,   0,  0,  0, 0, 16'h0000, 1, 2, 16'h0000, 16'h0000, 0);
        add("post_r12",  1,   0,  0,  0, 0, 16'h0000, 1, 2, 16'h0000, 16'h0000, 0);
        add("post_r30",  1,   0,  0,  0, 0, 16'h0000, 3, 0, 16'h0000, 16'h0000, 0);
        add("post_r13",  1,   0,  0,  0, 0, 16'h0000, 1, 3, 16'h0000, 16'h0000, 0);

        foreach (vecs[k]) begin
            exp_t e;
            @(posedge clk);
            #1;
            reset_n        = vecs[k].rstn;
            Clear          = vecs[k].clr;
            Stall          = vecs[k].stall;
            RegWrite       = vecs[k].rw;
            Write_Register = vecs[k].wr;
            Write_Data     = vecs[k].wd;
            Read_Register1 = vecs[k].r1;
            Read_Register2 = vecs[k].r2;
            e.name = vecs[k].name; e.e1 = vecs[k].e1; e.e2 = vecs[k].e2; e.ec = vecs[k].ec;
            sb.push_back(e);
        end

        for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
